// File: rtl/booth_ctrl_if.sv
// rtl/booth_ctrl_if.sv - booth_ctrl handshake and strobe bundle
interface booth_ctrl_if #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
);
    logic          start;
    logic          q0;
    logic          q_m1;
    logic          obus_ack;
    logic          c0;
    logic          c1;
    logic          c2;
    logic          c3;
    logic          c4;
    logic          c5;
    logic          c6;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    // Datapath / bench side: supplies start, Q bits and bus ack, observes strobes
    modport master (
        output start, q0, q_m1, obus_ack,
        input  c0, c1, c2, c3, c4, c5, c6, busy, done, cnt
    );

    // Sequencer side
    modport slave (
        input  start, q0, q_m1, obus_ack,
        output c0, c1, c2, c3, c4, c5, c6, busy, done, cnt
    );
endinterface

// File: rtl/booth_ctrl.sv
// rtl/booth_ctrl.sv - radix-2 Booth multiply sequencer (optional macro OBUS_HANDSHAKE_EN)
module booth_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst_b,
    booth_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INIT  = 4'd1,
        TEST  = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        SHIFT = 4'd5,
        OUT_A = 4'd6,
        OUT_Q = 4'd7,
        DONE  = 4'd8
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt_r;
    logic          last_iter;

    logic c0_r, c1_r, c2_r, c3_r, c4_r, c5_r, c6_r, busy_r, done_r;

    // The final shift is the one taken while cnt still reads N-1
    assign last_iter = (cnt_r == CW'(N - 1));

`ifdef OBUS_HANDSHAKE_EN
    logic out_adv;
    assign out_adv = bus.obus_ack;
`else
    logic out_adv;
    logic unused_obus_ack;
    assign out_adv         = 1'b1;
    assign unused_obus_ack = bus.obus_ack;
`endif

    // Next-state selection; Q bits only matter in TEST
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = INIT;
            INIT:    state_nxt = TEST;
            TEST: begin
                case ({bus.q0, bus.q_m1})
                    2'b01:   state_nxt = ADD;
                    2'b10:   state_nxt = SUB;
                    default: state_nxt = SHIFT;
                endcase
            end
            ADD:     state_nxt = SHIFT;
            SUB:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last_iter ? OUT_A : TEST;
            OUT_A:   if (out_adv) state_nxt = OUT_Q;
            OUT_Q:   if (out_adv) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, iteration count and strobes all registered; strobes are decoded
    // from the state being entered so they line up with the state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state  <= IDLE;
            cnt_r  <= '0;
            c0_r   <= 1'b0;
            c1_r   <= 1'b0;
            c2_r   <= 1'b0;
            c3_r   <= 1'b0;
            c4_r   <= 1'b0;
            c5_r   <= 1'b0;
            c6_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == INIT) begin
                cnt_r <= '0;
            end else if (state == SHIFT) begin
                cnt_r <= cnt_r + CW'(1);
            end

            c0_r   <= (state_nxt == INIT);
            c1_r   <= (state_nxt == INIT);
            c2_r   <= (state_nxt == ADD) || (state_nxt == SUB);
            c3_r   <= (state_nxt == SUB);
            c4_r   <= (state_nxt == SHIFT);
            c5_r   <= (state_nxt == OUT_A);
            c6_r   <= (state_nxt == OUT_Q);
            busy_r <= (state_nxt != IDLE);
            done_r <= (state_nxt == DONE);
        end
    end

    assign bus.c0   = c0_r;
    assign bus.c1   = c1_r;
    assign bus.c2   = c2_r;
    assign bus.c3   = c3_r;
    assign bus.c4   = c4_r;
    assign bus.c5   = c5_r;
    assign bus.c6   = c6_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.cnt  = cnt_r;

endmodule

// File: tb/tb_booth_ctrl.sv
// tb/tb_booth_ctrl.sv - scoreboard bench for booth_ctrl
module tb_booth_ctrl;
    localparam int N = 8;
`ifdef OBUS_HANDSHAKE_EN
    localparam int HS_EXTRA = 5;
`else
    localparam int HS_EXTRA = 0;
`endif

    typedef struct {
        int         cycles;
        int         nc2;
        logic [7:0] pat;
        int         gap;
    } exp_t;

    logic clk;
    logic rst_b;
    logic [7:0] mult;
    logic [7:0] qreg;
    logic       qm1;
    int checks;
    int failures;
    exp_t exp_q[$];

    booth_ctrl_if #(.N(N)) bus ();

    booth_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier register model feeding q0/q_m1 back to the sequencer
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            qreg <= 8'h00;
            qm1  <= 1'b0;
        end else begin
            if (bus.c1) qreg <= mult;
            if (bus.c0) qm1 <= 1'b0;
            if (bus.c4) begin
                qreg <= {1'b0, qreg[7:1]};
                qm1  <= qreg[0];
            end
        end
    end
    assign bus.q0   = qreg[0];
    assign bus.q_m1 = qm1;

    // Bus acceptor: withholds ack for the first 5 cycles of c5
    int c5_seen;
    always @(negedge clk) begin
        if (!rst_b || bus.done) begin
            c5_seen      = 0;
            bus.obus_ack = 1'b0;
        end else if (bus.c5) begin
            c5_seen      = c5_seen + 1;
            bus.obus_ack = (c5_seen >= 6);
        end
    end

    // Monitor: tracks each operation and compares against the queue at done
    int cyc, nc2, c5len, since_done;
    logic [7:0] pat;
    bit in_op;
    initial begin
        in_op = 0; cyc = 0; nc2 = 0; c5len = 0; since_done = 100; pat = 8'h00;
    end
    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) begin
            in_op = 0;
        end else begin
            since_done = since_done + 1;
            checks = checks + 1;
            if (($countones({bus.c2, bus.c4, bus.c5, bus.c6}) > 1) || (bus.c0 != bus.c1)) begin
                failures = failures + 1;
                $display("FAIL strobe_excl c0..c6=%b%b%b%b%b%b%b", bus.c0, bus.c1, bus.c2,
                         bus.c3, bus.c4, bus.c5, bus.c6);
            end
            if (bus.c0 && bus.c1) begin
                in_op = 1; cyc = 0; nc2 = 0; c5len = 0; pat = 8'h00;
                if (exp_q.size() > 0 && exp_q[0].gap >= 0) begin
                    checks = checks + 1;
                    if (since_done != exp_q[0].gap) begin
                        failures = failures + 1;
                        $display("FAIL restart_gap got=%0d want=%0d", since_done, exp_q[0].gap);
                    end
                end
            end
            if (in_op) cyc = cyc + 1;
            if (bus.c2) begin
                nc2 = nc2 + 1;
                pat = {pat[6:0], bus.c3};
            end
            if (bus.c5) c5len = c5len + 1;
            if (bus.done) begin
                since_done = 0;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_done got=1 want=0");
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.cycles || nc2 != e.nc2 || pat != e.pat ||
                        bus.cnt != 4'(N) || !bus.busy || c5len != 1 + HS_EXTRA) begin
                        failures = failures + 1;
                        $display("FAIL op_result got cyc=%0d nc2=%0d pat=%b cnt=%0d busy=%b c5len=%0d want cyc=%0d nc2=%0d pat=%b cnt=%0d busy=1 c5len=%0d",
                                 cyc, nc2, pat, bus.cnt, bus.busy, c5len,
                                 e.cycles, e.nc2, e.pat, N, 1 + HS_EXTRA);
                    end
                end
                in_op = 0;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int b = 0;
        @(negedge clk);
        while (bus.busy && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("idle_timeout", int'(bus.busy), 0);
    endtask

    task automatic wait_done();
        int b = 0;
        @(negedge clk);
        while (!bus.done && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("done_timeout", int'(bus.done), 1);
    endtask

    task automatic push(input int cy, input int n2, input logic [7:0] p, input int gap);
        exp_t e;
        e.cycles = cy + HS_EXTRA;
        e.nc2    = n2;
        e.pat    = p;
        e.gap    = gap;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] m, input int cy, input int n2, input logic [7:0] p);
        wait_idle();
        mult = m;
        push(cy, n2, p, -1);
        pulse_start();
        wait_done();
        @(negedge clk);
        @(negedge clk);
        check("cnt_hold", int'(bus.cnt), N);
        check("busy_after", int'(bus.busy), 0);
    endtask

    initial begin
        int b;
        checks = 0; failures = 0;
        bus.start = 1'b0;
        bus.obus_ack = 1'b0;
        mult = 8'h00;
        rst_b = 1'b0;
        #1;
        check("rst_outputs", int'({bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6,
                                   bus.busy, bus.done}), 0);
        check("rst_cnt", int'(bus.cnt), 0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;

        run_op(8'h00, 20, 0, 8'b0000_0000);
        run_op(8'h55, 28, 8, 8'b1010_1010);
        run_op(8'hFF, 21, 1, 8'b0000_0001);
        run_op(8'h01, 22, 2, 8'b0000_0010);
        run_op(8'h80, 21, 1, 8'b0000_0001);

        // start pulsed during ADD and then held through done
        wait_idle();
        mult = 8'h55;
        push(28, 8, 8'b1010_1010, -1);
        pulse_start();
        b = 0;
        while (!(bus.c2 && !bus.c3) && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("add_seen", int'(bus.c2 && !bus.c3), 1);
        bus.start = 1'b1;
        push(20, 0, 8'b0000_0000, 2);
        wait_done();
        mult = 8'h00;
        b = 0;
        @(negedge clk);
        while (!bus.c0 && b < 10) begin
            @(negedge clk);
            b++;
        end
        check("restart_init", int'(bus.c0), 1);
        bus.start = 1'b0;
        wait_done();

        // reset during the second SUB
        wait_idle();
        mult = 8'h55;
        pulse_start();
        b = 0;
        while (!(bus.c2 && bus.c3 && bus.cnt == 2) && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("sub_seen", int'(bus.c2 && bus.c3), 1);
        #2 rst_b = 1'b0;
        #1;
        check("midrst_outputs", int'({bus.c0, bus.c1, bus.c2, bus.c3, bus.c4, bus.c5, bus.c6,
                                      bus.busy, bus.done}), 0);
        check("midrst_cnt", int'(bus.cnt), 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_cnt", int'(bus.cnt), 0);

        run_op(8'hFF, 21, 1, 8'b0000_0001);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
